// File: rtl/estimador_sched_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | estimador_sched_pkg : shared encodings for the operand-mux scheduler |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
package estimador_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [1:0] SEL_D0 = 2'b00;
  localparam logic [1:0] SEL_D1 = 2'b01;
  localparam logic [1:0] SEL_D2 = 2'b10;

  localparam int LATENCY_DEFAULT = 4;

  function automatic logic [1:0] sel_from_gnt(input logic [2:0] gnt);
    case (gnt)
      3'b010:  sel_from_gnt = SEL_D1;
      3'b100:  sel_from_gnt = SEL_D2;
      default: sel_from_gnt = SEL_D0;
    endcase
  endfunction

  function automatic logic [2:0] owner_onehot(input logic [1:0] sel);
    case (sel)
      SEL_D0:  owner_onehot = 3'b001;
      SEL_D1:  owner_onehot = 3'b010;
      SEL_D2:  owner_onehot = 3'b100;
      default: owner_onehot = 3'b000;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/estimador_rr_arb3.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | estimador_rr_arb3 : 3-way round-robin arbiter, one-hot grant          |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module estimador_rr_arb3 (
  input  logic [2:0] req,
  input  logic [1:0] last,
  output logic [2:0] gnt
);

  // Search starts just after the last winner and wraps 2 -> 0.
  always_comb begin
    gnt = 3'b000;
    case (last)
      2'd0: begin
        if (req[1])      gnt = 3'b010;
        else if (req[2]) gnt = 3'b100;
        else if (req[0]) gnt = 3'b001;
      end
      2'd1: begin
        if (req[2])      gnt = 3'b100;
        else if (req[0]) gnt = 3'b001;
        else if (req[1]) gnt = 3'b010;
      end
      default: begin
        if (req[0])      gnt = 3'b001;
        else if (req[1]) gnt = 3'b010;
        else if (req[2]) gnt = 3'b100;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/estimador_mux_sched.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | estimador_mux_sched : schedules 3 requesters onto one pipelined unit  |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module estimador_mux_sched
  import estimador_sched_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = LATENCY_DEFAULT
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  ap_start,
  output logic                  ap_idle,
  output logic                  ap_done,
  input  logic [2:0]            req_valid,
  output logic [2:0]            req_ready,
  output logic [1:0]            mux_sel,
  output logic                  issue_valid,
  input  logic [DATA_WIDTH-1:0] unit_result,
  output logic [2:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data
);

  localparam int              c_cnt_w   = $clog2(LATENCY + 2);
  localparam logic [c_cnt_w-1:0] c_cnt_one = 1;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_done;
  logic [1:0]            r_last;
  logic [1:0]            r_sel;
  logic [2:0]            w_gnt;
  logic                  r_tag_v   [LATENCY];
  logic [1:0]            r_tag_own [LATENCY];
  logic [c_cnt_w-1:0]    r_inflight;
  logic [2:0]            r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_data;

  estimador_rr_arb3 u_arb (
    .req  (req_valid),
    .last (r_last),
    .gnt  (w_gnt)
  );

  assign req_ready   = (r_state == ST_RUN) ? w_gnt : 3'b000;
  assign issue_valid = |req_ready;
  assign mux_sel     = issue_valid ? sel_from_gnt(req_ready) : r_sel;
  assign ap_idle     = (r_state == ST_IDLE);
  assign ap_done     = r_done;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_data    = r_rsp_data;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (ap_start)          w_state_nxt = ST_RUN;
      ST_RUN:   if (!ap_start)         w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (r_inflight == '0)  w_state_nxt = ST_IDLE;
      default:                         w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      r_state <= ST_IDLE;
      r_done  <= 1'b0;
      r_last  <= 2'd2;
      r_sel   <= SEL_D0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= (r_state == ST_DRAIN) && (w_state_nxt == ST_IDLE);
      if (issue_valid) begin
        r_last <= mux_sel;
        r_sel  <= mux_sel;
      end
    end
  end

  // Owner tags travel alongside the unit's own pipeline.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      for (int i = 0; i < LATENCY; i++) begin
        r_tag_v[i]   <= 1'b0;
        r_tag_own[i] <= SEL_D0;
      end
    end else begin
      r_tag_v[0]   <= issue_valid;
      r_tag_own[0] <= mux_sel;
      for (int i = 1; i < LATENCY; i++) begin
        r_tag_v[i]   <= r_tag_v[i-1];
        r_tag_own[i] <= r_tag_own[i-1];
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      r_rsp_valid <= 3'b000;
      r_rsp_data  <= '0;
    end else if (r_tag_v[LATENCY-1]) begin
      r_rsp_valid <= owner_onehot(r_tag_own[LATENCY-1]);
      r_rsp_data  <= unit_result;
    end else begin
      r_rsp_valid <= 3'b000;
    end
  end

  // A response leaves the count only once it has been presented.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      r_inflight <= '0;
    end else begin
      case ({issue_valid, |r_rsp_valid})
        2'b10:   r_inflight <= r_inflight + c_cnt_one;
        2'b01:   r_inflight <= r_inflight - c_cnt_one;
        default: r_inflight <= r_inflight;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_estimador_mux_sched.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_estimador_mux_sched : randomized bench with a due-time queue model |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module tb_estimador_mux_sched;

  localparam int L  = 4;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [2:0]    valid = 3'b000;
  logic [DW-1:0] ures = '0;

  logic          ap_idle, ap_done, issue_valid;
  logic [2:0]    req_ready, rsp_valid;
  logic [1:0]    mux_sel;
  logic [DW-1:0] rsp_data;

  logic          idle1, done1, issue1;
  logic [2:0]    ready1, rsp1;
  logic [1:0]    sel1;
  logic [DW-1:0] data1;

  always #5 clk = ~clk;

  estimador_mux_sched #(.DATA_WIDTH(DW), .LATENCY(L)) dut (
    .ap_clk(clk), .ap_rst_n(rst_n), .ap_start(start), .ap_idle(ap_idle),
    .ap_done(ap_done), .req_valid(valid), .req_ready(req_ready),
    .mux_sel(mux_sel), .issue_valid(issue_valid), .unit_result(ures),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data)
  );

  estimador_mux_sched #(.DATA_WIDTH(DW), .LATENCY(1)) dut1 (
    .ap_clk(clk), .ap_rst_n(rst_n), .ap_start(start), .ap_idle(idle1),
    .ap_done(done1), .req_valid(valid), .req_ready(ready1),
    .mux_sel(sel1), .issue_valid(issue1), .unit_result(ures),
    .rsp_valid(rsp1), .rsp_data(data1)
  );

  // Reference model: each issue becomes a queue entry due L+1 cycles later.
  typedef struct { int due; int owner; logic [DW-1:0] data; } tag_t;
  tag_t          outq[$];
  int            m_mode = 0, m_last = 2, m_sel = 0, cyc = 0;
  logic          m_done = 1'b0;
  logic [DW-1:0] m_rsp_data = '0;

  logic          e_idle, e_done, e_issue;
  logic [2:0]    e_ready, e_rsp;
  logic [1:0]    e_sel;
  logic [DW-1:0] e_data;
  int            e_k = 0, e_inflight = 0;

  int n_tests = 0, n_fail = 0;

  function automatic void model_eval();
    e_idle  = (m_mode == 0);
    e_done  = m_done;
    e_ready = 3'b000;
    e_issue = 1'b0;
    e_k     = m_sel;
    if (m_mode == 1) begin
      for (int i = 0; i < 3; i++) begin
        int k;
        k = (m_last + 1 + i) % 3;
        if (valid[k] && !e_issue) begin
          e_ready[k] = 1'b1;
          e_issue    = 1'b1;
          e_k        = k;
        end
      end
    end
    e_sel  = 2'(e_k);
    e_rsp  = 3'b000;
    e_data = m_rsp_data;
    foreach (outq[j]) begin
      if (outq[j].due == cyc) begin
        e_rsp[outq[j].owner] = 1'b1;
        e_data = outq[j].data;
      end
    end
    e_inflight = outq.size();
  endfunction

  task automatic model_commit();
    tag_t t;
    if (!rst_n) begin
      m_mode = 0; m_last = 2; m_sel = 0; m_done = 1'b0; m_rsp_data = '0;
      outq.delete();
    end else begin
      for (int j = outq.size() - 1; j >= 0; j--) begin
        if (outq[j].due == cyc) begin
          m_rsp_data = outq[j].data;
          outq.delete(j);
        end
      end
      if (e_issue) begin
        t.due = cyc + L + 1; t.owner = e_k; t.data = '0;
        outq.push_back(t);
        m_last = e_k;
        m_sel  = e_k;
      end
      foreach (outq[j]) if (outq[j].due == cyc + 1) outq[j].data = ures;
      m_done = 1'b0;
      case (m_mode)
        0: if (start) m_mode = 1;
        1: if (!start) m_mode = 2;
        default: if (e_inflight == 0) begin m_mode = 0; m_done = 1'b1; end
      endcase
    end
    cyc++;
  endtask

  task automatic drive(input logic r, input logic s, input logic [2:0] v, input logic [DW-1:0] u);
    @(posedge clk);
    model_commit();
    #1;
    rst_n = r; start = s; valid = v; ures = u;
    #1;
    model_eval();
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b0, 3'b000, '0);
    drive(1'b0, 1'b1, 3'b111, $urandom);
    n_tests++;
    if ({ap_idle, ap_done, req_ready, issue_valid, mux_sel, rsp_valid} !== 11'b10_000_0_00_000) begin
      n_fail++;
      $display("FAIL reset_ctrl got %b want %b", {ap_idle, ap_done, req_ready, issue_valid, mux_sel, rsp_valid}, 11'b10_000_0_00_000);
    end
    n_tests++;
    if (rsp_data !== '0) begin
      n_fail++; $display("FAIL reset_data got %h want 0", rsp_data);
    end
    drive(1'b1, 1'b0, 3'b000, $urandom);
    n_tests++;
    if ({ap_idle, ap_done, req_ready, issue_valid, mux_sel, rsp_valid} !== {e_idle, e_done, e_ready, e_issue, e_sel, e_rsp}) begin
      n_fail++;
      $display("FAIL reset_release got %b want %b", {ap_idle, ap_done, req_ready, issue_valid, mux_sel, rsp_valid}, {e_idle, e_done, e_ready, e_issue, e_sel, e_rsp});
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] want3;
    drive(1'b0, 1'b0, 3'b000, '0);
    drive(1'b1, 1'b1, 3'b000, $urandom);
    for (int j = 0; j < 14; j++) begin
      drive(1'b1, 1'b1, (j < 6) ? 3'b111 : 3'b000, $urandom);
      n_tests++;
      if ({ap_idle, ap_done, req_ready, issue_valid, mux_sel, rsp_valid} !== {e_idle, e_done, e_ready, e_issue, e_sel, e_rsp}) begin
        n_fail++;
        $display("FAIL rr_model j=%0d got %b want %b", j, {ap_idle, ap_done, req_ready, issue_valid, mux_sel, rsp_valid}, {e_idle, e_done, e_ready, e_issue, e_sel, e_rsp});
      end
      if (j < 6) begin
        want3 = 3'(1 << (j % 3));
        n_tests++;
        if (req_ready !== want3 || mux_sel !== 2'(j % 3) || issue_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL rr_grant j=%0d got ready=%b sel=%0d want ready=%b sel=%0d", j, req_ready, mux_sel, want3, j % 3);
        end
      end
      want3 = (j >= 5 && j < 11) ? 3'(1 << ((j - 5) % 3)) : 3'b000;
      n_tests++;
      if (rsp_valid !== want3) begin
        n_fail++; $display("FAIL rr_rsp j=%0d got %b want %b", j, rsp_valid, want3);
      end
    end
  endtask

  task automatic test_single();
    drive(1'b0, 1'b0, 3'b000, '0);
    drive(1'b1, 1'b1, 3'b000, $urandom);
    drive(1'b1, 1'b1, 3'b010, $urandom);
    for (int j = 1; j <= 6; j++) begin
      drive(1'b1, 1'b1, 3'b000, (j == 4) ? 32'h3F80_0000 : $urandom);
      n_tests++;
      if (rsp_valid !== e_rsp || (e_rsp != 3'b000 && rsp_data !== e_data)) begin
        n_fail++; $display("FAIL single_model j=%0d got %b/%h want %b/%h", j, rsp_valid, rsp_data, e_rsp, e_data);
      end
      if (j == 5) begin
        n_tests++;
        if (rsp_valid !== 3'b010 || rsp_data !== 32'h3F80_0000) begin
          n_fail++; $display("FAIL single_rsp got %b/%h want 010/3f800000", rsp_valid, rsp_data);
        end
      end
    end
  endtask

  task automatic test_drain();
    int first_idle, done_cnt, done_at;
    drive(1'b0, 1'b0, 3'b000, '0);
    drive(1'b1, 1'b1, 3'b000, $urandom);
    drive(1'b1, 1'b0, 3'b000, $urandom);
    drive(1'b1, 1'b0, 3'b000, $urandom);
    n_tests++;
    if (ap_idle !== 1'b0 || ap_done !== 1'b0) begin
      n_fail++; $display("FAIL drain_empty_in got idle=%b done=%b want 0/0", ap_idle, ap_done);
    end
    drive(1'b1, 1'b0, 3'b000, $urandom);
    n_tests++;
    if (ap_idle !== 1'b1 || ap_done !== 1'b1) begin
      n_fail++; $display("FAIL drain_empty_out got idle=%b done=%b want 1/1", ap_idle, ap_done);
    end
    drive(1'b0, 1'b0, 3'b000, '0);
    drive(1'b1, 1'b1, 3'b000, $urandom);
    for (int j = 0; j < 3; j++) drive(1'b1, 1'b1, 3'b111, $urandom);
    drive(1'b1, 1'b0, 3'b000, $urandom);
    first_idle = -1; done_cnt = 0; done_at = -1;
    for (int j = 4; j < 12; j++) begin
      drive(1'b1, 1'b1, 3'b000, $urandom);
      n_tests++;
      if ({ap_idle, ap_done, issue_valid, rsp_valid} !== {e_idle, e_done, e_issue, e_rsp}) begin
        n_fail++; $display("FAIL drain_model j=%0d got %b want %b", j, {ap_idle, ap_done, issue_valid, rsp_valid}, {e_idle, e_done, e_issue, e_rsp});
      end
      if (ap_idle === 1'b1 && first_idle < 0) first_idle = j;
      if (ap_done === 1'b1) begin done_cnt++; done_at = j; end
    end
    n_tests++;
    if (first_idle !== 9 || done_cnt !== 1 || done_at !== 9) begin
      n_fail++; $display("FAIL drain_len got idle_at=%0d done_cnt=%0d done_at=%0d want 9/1/9", first_idle, done_cnt, done_at);
    end
  endtask

  task automatic test_mid_reset();
    drive(1'b0, 1'b0, 3'b000, '0);
    drive(1'b1, 1'b1, 3'b000, $urandom);
    for (int j = 0; j < 3; j++) drive(1'b1, 1'b1, 3'b111, $urandom);
    drive(1'b0, 1'b0, 3'b000, $urandom);
    for (int j = 0; j < 10; j++) begin
      drive(1'b1, 1'b0, 3'b000, $urandom);
      n_tests++;
      if (rsp_valid !== 3'b000) begin
        n_fail++; $display("FAIL midrst_rsp j=%0d got %b want 000", j, rsp_valid);
      end
      if (j == 0) begin
        n_tests++;
        if ({ap_idle, ap_done, req_ready, issue_valid, mux_sel} !== 8'b10_000_0_00 || rsp_data !== '0) begin
          n_fail++; $display("FAIL midrst_vals got %b/%h want 10000000/0", {ap_idle, ap_done, req_ready, issue_valid, mux_sel}, rsp_data);
        end
      end
    end
  endtask

  task automatic test_idle_block();
    drive(1'b0, 1'b0, 3'b000, '0);
    for (int j = 0; j < 4; j++) begin
      drive(1'b1, 1'b0, 3'b111, $urandom);
      n_tests++;
      if (req_ready !== 3'b000 || issue_valid !== 1'b0 || ap_idle !== 1'b1) begin
        n_fail++; $display("FAIL idle_block got ready=%b issue=%b idle=%b want 000/0/1", req_ready, issue_valid, ap_idle);
      end
    end
  endtask

  task automatic test_random();
    logic s, r;
    s = 1'b0;
    drive(1'b0, 1'b0, 3'b000, '0);
    for (int j = 0; j < 400; j++) begin
      if ($urandom_range(0, 9) == 0) s = ~s;
      r = ($urandom_range(0, 79) != 0);
      drive(r, s, 3'($urandom), $urandom);
      n_tests++;
      if ({ap_idle, ap_done, req_ready, issue_valid, mux_sel, rsp_valid} !== {e_idle, e_done, e_ready, e_issue, e_sel, e_rsp}
          || (e_rsp != 3'b000 && rsp_data !== e_data)) begin
        n_fail++;
        $display("FAIL rand j=%0d got %b/%h want %b/%h", j, {ap_idle, ap_done, req_ready, issue_valid, mux_sel, rsp_valid}, rsp_data, {e_idle, e_done, e_ready, e_issue, e_sel, e_rsp}, e_data);
      end
      n_tests++;
      if (int'(dut.r_inflight) !== e_inflight) begin
        n_fail++; $display("FAIL rand_inflight j=%0d got %0d want %0d", j, dut.r_inflight, e_inflight);
      end
    end
  endtask

  task automatic test_latency1();
    logic [2:0]    want3;
    logic [DW-1:0] prev_u, u;
    int            want_n;
    drive(1'b0, 1'b0, 3'b000, '0);
    drive(1'b1, 1'b1, 3'b000, $urandom);
    prev_u = '0;
    for (int j = 0; j < 12; j++) begin
      u = $urandom;
      drive(1'b1, 1'b1, 3'b111, u);
      want3  = (j >= 2) ? 3'(1 << ((j - 2) % 3)) : 3'b000;
      want_n = (j < 2) ? j : 2;
      n_tests++;
      if ({idle1, done1, issue1, ready1, sel1, rsp1} !== {1'b0, 1'b0, 1'b1, 3'(1 << (j % 3)), 2'(j % 3), want3}
          || (j >= 2 && data1 !== prev_u)) begin
        n_fail++;
        $display("FAIL lat1_out j=%0d got %b/%h want %b/%h", j, {idle1, done1, issue1, ready1, sel1, rsp1}, data1, {1'b0, 1'b0, 1'b1, 3'(1 << (j % 3)), 2'(j % 3), want3}, prev_u);
      end
      n_tests++;
      if (int'(dut1.r_inflight) !== want_n) begin
        n_fail++; $display("FAIL lat1_inflight j=%0d got %0d want %0d", j, dut1.r_inflight, want_n);
      end
      prev_u = u;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_drain();
    test_mid_reset();
    test_idle_block();
    test_latency1();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/estimador_mux_sched.md
ESTIMADOR_MUX_SCHED -- requirements
Module: estimador_mux_sched

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of the shared-unit result and response data.
REQ-002 Parameter LATENCY, default 4, legal range 1..16: fixed cycles from issue to unit_result valid.
REQ-003 ap_clk  in  1  sole clock, all state updates on the rising edge.
REQ-004 ap_rst_n  in  1  reset, synchronous, active-low.
REQ-005 ap_start  in  1  run request, level-sensitive.
REQ-006 ap_idle  out  1  high while the FSM is in IDLE.
REQ-007 ap_done  out  1  one-cycle pulse when a drain completes.
REQ-008 req_valid  in  3  per-requester operand-valid; bit k belongs to requester k.
REQ-009 req_ready  out  3  one-hot grant; a request is accepted when req_valid[k] and req_ready[k] are both high.
REQ-010 mux_sel  out  2  select for the shared 3:1 operand mux: 00 selects din0, 01 selects din1, 10 selects din2; 11 is never driven.
REQ-011 issue_valid  out  1  high in the cycle an operand is presented to the shared unit.
REQ-012 unit_result  in  DATA_WIDTH  shared-unit output, valid LATENCY cycles after issue_valid.
REQ-013 rsp_valid  out  3  one-hot response strobe to the owning requester.
REQ-014 rsp_data  out  DATA_WIDTH  registered copy of unit_result.

Function
REQ-015 FSM states are IDLE, RUN and DRAIN. IDLE goes to RUN when ap_start=1. RUN goes to DRAIN when ap_start=0. DRAIN goes to IDLE when the in-flight count is 0.
REQ-016 DRAIN always ends in IDLE, even if ap_start is asserted again during DRAIN; RUN is re-entered from IDLE on a later cycle.
REQ-017 ap_done is high only in the first IDLE cycle after DRAIN; ap_done is never asserted on the path out of reset.
REQ-018 Grants are issued only in RUN, at most one per cycle. req_ready is combinational from req_valid and the priority pointer, and is all-zero when no req_valid bit is set.
REQ-019 Requesters shall not make req_valid depend on req_ready.
REQ-020 Arbitration is round-robin. Priority starts at (last_grant+1) mod 3 and wraps 2→0. last_grant updates only on an accepted request.
REQ-021 On a grant to requester k, in the same cycle: issue_valid=1 and mux_sel equals the encoding of k.
REQ-022 When no request is granted, mux_sel holds its previous value and issue_valid=0.
REQ-023 A LATENCY-deep tag pipeline carries {valid, owner}. A response is presented LATENCY+1 cycles after issue: rsp_valid[owner]=1 and rsp_data=unit_result registered at cycle LATENCY.
REQ-024 The in-flight counter (range 0..LATENCY+1) increments on issue and decrements on response; if both happen in the same cycle, it is unchanged.
REQ-025 Back-to-back issues every cycle are legal and produce back-to-back responses in issue order.
REQ-026 Entering DRAIN with 0 in flight spends exactly one cycle in DRAIN.

Reset
REQ-027 When ap_rst_n=0 at a clock edge, the block resets to: FSM=IDLE, ap_idle=1, ap_done=0, req_ready=000, issue_valid=0, mux_sel=00, rsp_valid=000, rsp_data=0, last_grant=2 (requester 0 first), in-flight=0, tag pipeline cleared.
REQ-028 A reset in mid-operation discards all in-flight tags; no rsp_valid occurs for any pre-reset issue.

Structure
REQ-029 Shared package estimador_sched_pkg holds the FSM state encodings, the mux_sel encodings (SEL_D0/SEL_D1/SEL_D2), and the LATENCY default.
REQ-030 The round-robin grant logic is a sub-module, estimador_rr_arb3 (inputs: req[2:0], last[1:0]; output: one-hot gnt[2:0]).

Verification
REQ-031 Reset, then ap_start=1 and req_valid=111 held for 6 cycles → grants 0,1,2,0,1,2; mux_sel 00,01,10,00,01,10; rsp_valid follows with the same order, LATENCY+1=5 cycles later.
REQ-032 Only req_valid[1]=1 in RUN, unit_result=0x3F800000 at issue+4 → rsp_valid=010 and rsp_data=0x3F800000 at issue+5.
REQ-033 Three issues, then ap_start=0 → DRAIN until in-flight=0, then one ap_done pulse with ap_idle=1; ap_start=1 during DRAIN does not shorten or skip DRAIN.
REQ-034 ap_rst_n=0 for one cycle with 3 operations in flight → no rsp_valid afterwards, and all outputs at their reset values.
REQ-035 Run with LATENCY=1, issuing every cycle → in-flight count stays at 2 during the steady state; the counter neither overflows nor underflows.
REQ-036 In IDLE with req_valid=111 and ap_start=0 → req_ready=000 and issue_valid=0.
